// File: rtl/snake_pkg.sv
// Shared encodings and helpers for the snake head position engine.
package snake_pkg;

    localparam int COORD_W = 5;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_PAUSED = 2'b10
    } state_e;

    // A 180-degree reversal differs only in the upper encoding bit.
    function automatic logic [1:0] opposite_dir(input logic [1:0] d);
        return d ^ 2'b10;
    endfunction

endpackage

// File: rtl/snake_axis_step.sv
// One-axis toroidal step: +1 / -1 with wrap between 0 and limit_i.
module snake_axis_step
    import snake_pkg::*;
(
    input  logic [COORD_W-1:0] coord_i,
    input  logic               inc_i,
    input  logic               dec_i,
    input  logic [COORD_W-1:0] limit_i,
    output logic [COORD_W-1:0] next_o,
    output logic               wrap_o
);

    // Compute the neighbouring coordinate; hold when neither inc nor dec.
    always_comb begin
        next_o = coord_i;
        wrap_o = 1'b0;
        if (inc_i) begin
            if (coord_i == limit_i) begin
                next_o = '0;
                wrap_o = 1'b1;
            end else begin
                next_o = coord_i + COORD_W'(1);
            end
        end else if (dec_i) begin
            if (coord_i == '0) begin
                next_o = limit_i;
                wrap_o = 1'b1;
            end else begin
                next_o = coord_i - COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/snake_head_stepper.sv
// Snake head position engine: run/pause FSM, direction filtering and
// one-cell toroidal moves on each game tick. All outputs are registered.
//
// Handshake: dir_req is sampled only on cycles where dir_req_valid=1; there
// is no ready -- every valid request is either accepted into pending or
// answered with a one-cycle req_rejected pulse on the following cycle.
module snake_head_stepper
    import snake_pkg::*;
#(
    parameter int         GRID_W    = 32,
    parameter int         GRID_H    = 24,
    parameter int         START_X   = 16,
    parameter int         START_Y   = 12,
    parameter logic [1:0] START_DIR = 2'b01
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       start,
    input  logic       halt,
    input  logic       pause,
    input  logic       step,
    input  logic [1:0] dir_req,
    input  logic       dir_req_valid,
    output logic [4:0] head_x,
    output logic [4:0] head_y,
    output logic [1:0] dir,
    output logic       moved,
    output logic       wrapped,
    output logic       req_rejected,
    output logic       running,
    output logic [1:0] dbg_state
);

    localparam logic [COORD_W-1:0] X_LIMIT = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LIMIT = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] X_START = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] Y_START = COORD_W'(START_Y);

    state_e             state_q, state_d;
    logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [1:0]         dir_q, dir_d, pend_q, pend_d;
    logic               moved_q, moved_d, wrapped_q, wrapped_d, rej_q, rej_d;

    logic               req_legal;
    logic [1:0]         step_dir;
    logic [COORD_W-1:0] x_next, y_next;
    logic               x_wrap, y_wrap;

    // Legality is judged against the committed direction, not pending, so
    // several non-reversing requests inside one tick are all accepted.
    assign req_legal = dir_req_valid && (dir_req != opposite_dir(dir_q));
    assign step_dir  = req_legal ? dir_req : pend_q;

    snake_axis_step u_x_step (
        .coord_i (x_q),
        .inc_i   (step_dir == DIR_RIGHT),
        .dec_i   (step_dir == DIR_LEFT),
        .limit_i (X_LIMIT),
        .next_o  (x_next),
        .wrap_o  (x_wrap)
    );

    snake_axis_step u_y_step (
        .coord_i (y_q),
        .inc_i   (step_dir == DIR_DOWN),
        .dec_i   (step_dir == DIR_UP),
        .limit_i (Y_LIMIT),
        .next_o  (y_next),
        .wrap_o  (y_wrap)
    );

    // Register state, position, direction and the one-cycle pulses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            x_q       <= X_START;
            y_q       <= Y_START;
            dir_q     <= START_DIR;
            pend_q    <= START_DIR;
            moved_q   <= 1'b0;
            wrapped_q <= 1'b0;
            rej_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            x_q       <= x_d;
            y_q       <= y_d;
            dir_q     <= dir_d;
            pend_q    <= pend_d;
            moved_q   <= moved_d;
            wrapped_q <= wrapped_d;
            rej_q     <= rej_d;
        end
    end

    // Next-state: halt first, then per-state request, step and pause handling.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        dir_d     = dir_q;
        pend_d    = pend_q;
        moved_d   = 1'b0;
        wrapped_d = 1'b0;
        rej_d     = 1'b0;
        if (halt) begin
            state_d = ST_IDLE;
            x_d     = X_START;
            y_d     = Y_START;
            dir_d   = START_DIR;
            pend_d  = START_DIR;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    rej_d = dir_req_valid;
                    if (start) state_d = ST_RUN;
                end
                ST_RUN, ST_PAUSED: begin
                    rej_d = dir_req_valid && !req_legal;
                    if (req_legal) pend_d = dir_req;
                    if (state_q == ST_RUN) begin
                        if (step) begin
                            dir_d     = step_dir;
                            pend_d    = step_dir;
                            x_d       = x_next;
                            y_d       = y_next;
                            moved_d   = 1'b1;
                            wrapped_d = x_wrap | y_wrap;
                        end
                        if (pause) state_d = ST_PAUSED;
                    end else if (!pause) begin
                        state_d = ST_RUN;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign head_x       = x_q;
    assign head_y       = y_q;
    assign dir          = dir_q;
    assign moved        = moved_q;
    assign wrapped      = wrapped_q;
    assign req_rejected = rej_q;
    assign running      = (state_q == ST_RUN);
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_snake_head_stepper.sv
// Self-checking bench for snake_head_stepper (default 32x24 grid).
module tb_snake_head_stepper;

    localparam int W = 32;
    localparam int H = 24;
    localparam int SX = 16;
    localparam int SY = 12;
    localparam int SD = 1;

    logic       clk;
    logic       resetn;
    logic       start, halt, pause, step, dir_req_valid;
    logic [1:0] dir_req;
    logic [4:0] head_x, head_y;
    logic [1:0] dir;
    logic       moved, wrapped, req_rejected, running;
    logic [1:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: mode 0 idle, 1 run, 2 paused; plain integer grid math.
    int m_mode, m_x, m_y, m_dir, m_pend, m_moved, m_wrapped, m_rej;

    snake_head_stepper dut (
        .clk           (clk),
        .resetn        (resetn),
        .start         (start),
        .halt          (halt),
        .pause         (pause),
        .step          (step),
        .dir_req       (dir_req),
        .dir_req_valid (dir_req_valid),
        .head_x        (head_x),
        .head_y        (head_y),
        .dir           (dir),
        .moved         (moved),
        .wrapped       (wrapped),
        .req_rejected  (req_rejected),
        .running       (running),
        .dbg_state     (dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic model_reset();
        m_mode = 0; m_x = SX; m_y = SY; m_dir = SD; m_pend = SD;
        m_moved = 0; m_wrapped = 0; m_rej = 0;
    endtask

    // Drive one cycle of inputs, advance the model across the edge, settle.
    task automatic drive(input logic s, input logic h, input logic p, input logic st,
                         input logic [1:0] dr, input logic v);
        int dx, dy, rx, ry;
        start = s; halt = h; pause = p; step = st; dir_req = dr; dir_req_valid = v;
        @(posedge clk);
        m_moved = 0; m_wrapped = 0; m_rej = 0;
        if (h) begin
            m_mode = 0; m_x = SX; m_y = SY; m_dir = SD; m_pend = SD;
        end else if (m_mode == 0) begin
            if (v) m_rej = 1;
            if (s) m_mode = 1;
        end else begin
            if (v && int'(dr) == (m_dir + 2) % 4) m_rej = 1;
            else if (v) m_pend = int'(dr);
            if (m_mode == 1 && st) begin
                m_dir = m_pend;
                dx = (m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0;
                dy = (m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0;
                rx = m_x + dx;
                ry = m_y + dy;
                m_wrapped = (rx < 0 || rx >= W || ry < 0 || ry >= H) ? 1 : 0;
                m_x = (rx + W) % W;
                m_y = (ry + H) % H;
                m_moved = 1;
            end
            if (m_mode == 1 && p) m_mode = 2;
            else if (m_mode == 2 && !p) m_mode = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        start = 0; halt = 0; pause = 0; step = 0; dir_req = 2'b00; dir_req_valid = 0;
        model_reset();
        #12;
        n_cmp++; if (head_x !== 5'd16) begin n_bad++; $display("FAIL reset_x: got %0d want 16", head_x); end
        n_cmp++; if (head_y !== 5'd12) begin n_bad++; $display("FAIL reset_y: got %0d want 12", head_y); end
        n_cmp++; if (dir !== 2'b01) begin n_bad++; $display("FAIL reset_dir: got %0d want 1", dir); end
        n_cmp++; if ({moved, wrapped, req_rejected, running} !== 4'b0000) begin
            n_bad++; $display("FAIL reset_pulses: got %b want 0000", {moved, wrapped, req_rejected, running});
        end
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_first_step();
        drive(1, 0, 0, 0, 2'b00, 0);
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL start_running: got %0d want 1", running); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd17 || head_y !== 5'd12) begin
            n_bad++; $display("FAIL first_step_pos: got (%0d,%0d) want (17,12)", head_x, head_y);
        end
        n_cmp++; if ({dir, moved, wrapped} !== 4'b0110) begin
            n_bad++; $display("FAIL first_step_flags: got dir=%0d moved=%0d wrapped=%0d want 1,1,0", dir, moved, wrapped);
        end
        drive(0, 0, 0, 0, 2'b00, 0);
        n_cmp++; if (moved !== 1'b0) begin n_bad++; $display("FAIL moved_one_cycle: got %0d want 0", moved); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 14; i++) drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd31) begin n_bad++; $display("FAIL reach_x31: got %0d want 31", head_x); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd0 || moved !== 1'b1 || wrapped !== 1'b1) begin
            n_bad++; $display("FAIL wrap_right: got x=%0d moved=%0d wrapped=%0d want 0,1,1", head_x, moved, wrapped);
        end
        drive(0, 0, 0, 1, 2'b00, 1);
        n_cmp++; if (head_y !== 5'd11 || head_x !== 5'd0 || dir !== 2'b00 || wrapped !== 1'b0) begin
            n_bad++; $display("FAIL turn_up: got (%0d,%0d) dir=%0d wrapped=%0d want (0,11) 0 0", head_x, head_y, dir, wrapped);
        end
        for (int i = 0; i < 11; i++) drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_y !== 5'd0) begin n_bad++; $display("FAIL reach_y0: got %0d want 0", head_y); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_y !== 5'd23 || wrapped !== 1'b1) begin
            n_bad++; $display("FAIL wrap_up: got y=%0d wrapped=%0d want 23,1", head_y, wrapped);
        end
    endtask

    task automatic test_dir_requests();
        drive(0, 0, 0, 1, 2'b01, 1);                       // turn RIGHT: x=1
        drive(0, 0, 0, 0, 2'b11, 1);                       // LEFT is a reversal
        n_cmp++; if (req_rejected !== 1'b1) begin n_bad++; $display("FAIL reject_reverse: got %0d want 1", req_rejected); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd2 || req_rejected !== 1'b0) begin
            n_bad++; $display("FAIL after_reject: got x=%0d rej=%0d want 2,0", head_x, req_rejected);
        end
        drive(0, 0, 0, 1, 2'b00, 1);                       // UP with step
        n_cmp++; if (dir !== 2'b00 || head_y !== 5'd22 || head_x !== 5'd2) begin
            n_bad++; $display("FAIL same_cycle_up: got dir=%0d (%0d,%0d) want 0 (2,22)", dir, head_x, head_y);
        end
        drive(0, 0, 0, 1, 2'b01, 1);                       // RIGHT: x=3
        drive(0, 0, 0, 0, 2'b00, 1);                       // UP accepted
        drive(0, 0, 0, 0, 2'b10, 1);                       // DOWN accepted too, wins
        n_cmp++; if (req_rejected !== 1'b0) begin n_bad++; $display("FAIL down_vs_committed: got rej=%0d want 0", req_rejected); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (dir !== 2'b10 || head_y !== 5'd23 || head_x !== 5'd3) begin
            n_bad++; $display("FAIL last_wins: got dir=%0d (%0d,%0d) want 2 (3,23)", dir, head_x, head_y);
        end
    endtask

    task automatic test_pause();
        drive(0, 0, 0, 1, 2'b01, 1);                       // RIGHT: (4,23)
        drive(0, 0, 1, 0, 2'b00, 0);
        n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL paused_running: got %0d want 0", running); end
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 2'b00, 0);
            n_cmp++; if (moved !== 1'b0 || head_x !== 5'd4 || head_y !== 5'd23) begin
                n_bad++; $display("FAIL paused_step%0d: got moved=%0d (%0d,%0d) want 0 (4,23)", i, moved, head_x, head_y);
            end
        end
        drive(0, 0, 1, 0, 2'b10, 1);
        n_cmp++; if (req_rejected !== 1'b0) begin n_bad++; $display("FAIL paused_req: got rej=%0d want 0", req_rejected); end
        drive(0, 0, 0, 0, 2'b00, 0);
        n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL unpause: got %0d want 1", running); end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_y !== 5'd0 || head_x !== 5'd4 || wrapped !== 1'b1 || dir !== 2'b10) begin
            n_bad++; $display("FAIL down_after_pause: got (%0d,%0d) wr=%0d dir=%0d want (4,0) 1 2", head_x, head_y, wrapped, dir);
        end
    endtask

    task automatic test_halt();
        drive(0, 1, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd16 || head_y !== 5'd12 || dir !== 2'b01 || running !== 1'b0 || moved !== 1'b0) begin
            n_bad++; $display("FAIL halt: got (%0d,%0d) dir=%0d run=%0d moved=%0d want (16,12) 1 0 0", head_x, head_y, dir, running, moved);
        end
        for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd16 || moved !== 1'b0) begin
            n_bad++; $display("FAIL idle_steps: got x=%0d moved=%0d want 16,0", head_x, moved);
        end
        drive(0, 0, 0, 0, 2'b10, 1);
        n_cmp++; if (req_rejected !== 1'b1) begin n_bad++; $display("FAIL idle_req: got %0d want 1", req_rejected); end
        drive(1, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (moved !== 1'b0 || head_x !== 5'd16 || running !== 1'b1) begin
            n_bad++; $display("FAIL start_with_step: got moved=%0d x=%0d run=%0d want 0,16,1", moved, head_x, running);
        end
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (head_x !== 5'd17) begin n_bad++; $display("FAIL step_after_start: got %0d want 17", head_x); end
    endtask

    task automatic test_async_reset();
        drive(0, 0, 0, 1, 2'b00, 0);                       // moved high now
        #3;
        resetn = 1'b0;
        model_reset();
        #1;
        n_cmp++; if (head_x !== 5'd16 || head_y !== 5'd12 || dir !== 2'b01) begin
            n_bad++; $display("FAIL async_pos: got (%0d,%0d) dir=%0d want (16,12) 1", head_x, head_y, dir);
        end
        n_cmp++; if ({moved, wrapped, req_rejected, running} !== 4'b0000) begin
            n_bad++; $display("FAIL async_pulses: got %b want 0000", {moved, wrapped, req_rejected, running});
        end
        @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1, 2'b00, 0);
        n_cmp++; if (moved !== 1'b0 || running !== 1'b0) begin
            n_bad++; $display("FAIL after_reset: got moved=%0d run=%0d want 0,0", moved, running);
        end
    endtask

    task automatic test_random();
        logic s, h, p, st, v;
        logic [1:0] dr;
        p = 1'b0;
        drive(1, 0, 0, 0, 2'b00, 0);
        for (int i = 0; i < 400; i++) begin
            h  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 7) == 0) p = ~p;
            st = ($urandom_range(0, 1) == 0);
            v  = ($urandom_range(0, 2) == 0);
            dr = 2'($urandom_range(0, 3));
            drive(s, h, p, st, dr, v);
            n_cmp++; if (head_x !== 5'(m_x) || head_y !== 5'(m_y) || dir !== 2'(m_dir)) begin
                n_bad++; $display("FAIL rnd_pos@%0d: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i, head_x, head_y, dir, m_x, m_y, m_dir);
            end
            n_cmp++; if (moved !== 1'(m_moved) || wrapped !== 1'(m_wrapped) || req_rejected !== 1'(m_rej)
                         || running !== 1'(m_mode == 1)) begin
                n_bad++; $display("FAIL rnd_flags@%0d: got m=%0d w=%0d r=%0d run=%0d want %0d %0d %0d %0d",
                                  i, moved, wrapped, req_rejected, running, m_moved, m_wrapped, m_rej, (m_mode == 1));
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_step();
        test_wrap();
        test_dir_requests();
        test_pause();
        test_halt();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
